// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced button levels into one ordered event
// stream. Each button runs a timing FSM (PRESS / SHORT / LONG / REPEAT), events
// wait in a one-deep slot per button, and a round-robin arbiter feeds a single
// valid/ready output register. Overwriting an unsent event sets a sticky flag.
module button_event_ctrl #(
    parameter int NUM_BTN       = 4,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_BTN-1:0]         btn_in,
    input  logic                       evt_ready_in,
    input  logic                       clr_overflow_in,
    output logic                       evt_valid_out,
    output logic [$clog2(NUM_BTN)-1:0] evt_btn_out,
    output logic [1:0]                 evt_code_out,
    output logic [NUM_BTN-1:0]         overflow_out
);

    localparam int BTN_W   = $clog2(NUM_BTN);
    localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] EVT_PRESS  = 2'd0;
    localparam logic [1:0] EVT_SHORT  = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        HELD     = 2'd3
    } btn_state_t;

    logic [NUM_BTN-1:0] btn_p0;

    btn_state_t         state_q [NUM_BTN];
    btn_state_t         state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] emit;
    logic [1:0]         emit_code [NUM_BTN];

    logic [NUM_BTN-1:0] slot_vld_p1;
    logic [1:0]         slot_code_p1 [NUM_BTN];

    logic [BTN_W-1:0]   rr_ptr_q;
    logic               win_vld;
    logic [BTN_W-1:0]   win_idx;
    logic               out_load;
    logic [NUM_BTN-1:0] grant;

    // Stage 0: sample button levels; reset value "pressed" keeps held buttons in WAIT_LOW
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            btn_p0 <= '1;
        end else begin
            btn_p0 <= btn_in;
        end
    end

    // Per-button FSM state and hold counter registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= WAIT_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-button next-state, counter and event emission
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            emit[i]      = 1'b0;
            emit_code[i] = EVT_PRESS;
            case (state_q[i])
                WAIT_LOW: begin
                    if (!btn_p0[i]) state_d[i] = IDLE;
                end
                IDLE: begin
                    if (btn_p0[i]) begin
                        state_d[i]   = PRESSED;
                        cnt_d[i]     = '0;
                        emit[i]      = 1'b1;
                        emit_code[i] = EVT_PRESS;
                    end
                end
                PRESSED: begin
                    if (!btn_p0[i]) begin
                        state_d[i]   = IDLE;
                        emit[i]      = 1'b1;
                        emit_code[i] = EVT_SHORT;
                    end else if (cnt_q[i] == LONG_LAST) begin
                        state_d[i]   = HELD;
                        cnt_d[i]     = '0;
                        emit[i]      = 1'b1;
                        emit_code[i] = EVT_LONG;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_p0[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == REPEAT_LAST) begin
                        cnt_d[i]     = '0;
                        emit[i]      = 1'b1;
                        emit_code[i] = EVT_REPEAT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: state_d[i] = WAIT_LOW;
            endcase
        end
    end

    // Round-robin search over pending slots, starting just after the last grant
    always_comb begin
        int               idx;
        logic [BTN_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_BTN) idx = idx - NUM_BTN;
            cand = BTN_W'(idx);
            if (!win_vld && slot_vld_p1[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign out_load = !evt_valid_out || evt_ready_in;
    assign grant    = (out_load && win_vld) ? (NUM_BTN'(1) << win_idx) : '0;

    // Stage 1: pending slots; a fresh emit beats a same-cycle grant clear
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_vld_p1  <= '0;
            overflow_out <= '0;
            for (int i = 0; i < NUM_BTN; i++) slot_code_p1[i] <= EVT_PRESS;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (emit[i]) begin
                    slot_vld_p1[i]  <= 1'b1;
                    slot_code_p1[i] <= emit_code[i];
                end else if (grant[i]) begin
                    slot_vld_p1[i] <= 1'b0;
                end
                if (emit[i] && slot_vld_p1[i] && !grant[i]) begin
                    overflow_out[i] <= 1'b1;
                end else if (clr_overflow_in) begin
                    overflow_out[i] <= 1'b0;
                end
            end
        end
    end

    // Stage 2: output register, reloaded only when empty or being accepted
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            evt_valid_out <= 1'b0;
            evt_btn_out   <= '0;
            evt_code_out  <= EVT_PRESS;
            rr_ptr_q      <= BTN_W'(NUM_BTN - 1);
        end else if (out_load) begin
            evt_valid_out <= win_vld;
            if (win_vld) begin
                evt_btn_out  <= win_idx;
                evt_code_out <= slot_code_p1[win_idx];
                rr_ptr_q     <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus pushes expected events
// (button, code, optional acceptance cycle); a negedge monitor pops on every
// handshake and compares.
module tb_button_event_ctrl;

    localparam int NB = 4;
    localparam int LC = 8;
    localparam int RC = 4;

    localparam int PRESS  = 0;
    localparam int SHORT  = 1;
    localparam int LONG   = 2;
    localparam int REPEAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic          ready;
    logic          clr;
    logic          valid;
    logic [1:0]    bidx;
    logic [1:0]    code;
    logic [NB-1:0] ovf;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .NUM_BTN       (NB),
        .LONG_CYCLES   (LC),
        .REPEAT_CYCLES (RC)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .btn_in          (btn),
        .evt_ready_in    (ready),
        .clr_overflow_in (clr),
        .evt_valid_out   (valid),
        .evt_btn_out     (bidx),
        .evt_code_out    (code),
        .overflow_out    (ovf)
    );

    typedef struct {
        int b;
        int c;
        int t;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   p;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted event must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid && ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got btn=%0d code=%0d cyc=%0d, required no event",
                         bidx, code, cyc);
            end else begin
                e = sbq.pop_front();
                if (int'(bidx) != e.b || int'(code) != e.c || (e.t >= 0 && cyc != e.t)) begin
                    errors++;
                    $display("FAIL event got btn=%0d code=%0d cyc=%0d, required btn=%0d code=%0d cyc=%0d",
                             bidx, code, cyc, e.b, e.c, e.t);
                end
            end
        end
    end

    task automatic expect_evt(input int b, input int c, input int t);
        exp_t e;
        e.b = b;
        e.c = c;
        e.t = t;
        sbq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        chk(name, sbq.size(), 0);
        sbq.delete();
        tick(6);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        ready = 1'b1;
        clr   = 1'b0;
        tick(2);
        chk("rst_valid", valid, 0);
        chk("rst_btn", bidx, 0);
        chk("rst_code", code, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick(3);

        // Short tap on button 1
        p = cyc;
        expect_evt(1, PRESS, p + 3);
        expect_evt(1, SHORT, p + 6);
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        drain("tap_drain");
        chk("tap_ovf", ovf, 0);

        // Long hold on button 2: LONG 8 after PRESS, then three REPEATs 4 apart
        p = cyc;
        expect_evt(2, PRESS,  p + 3);
        expect_evt(2, LONG,   p + 11);
        expect_evt(2, REPEAT, p + 15);
        expect_evt(2, REPEAT, p + 19);
        expect_evt(2, REPEAT, p + 23);
        btn[2] = 1'b1;
        tick(22);
        btn[2] = 1'b0;
        drain("hold_drain");

        // Simultaneous presses: index 0 first after reset
        reset_dut();
        p = cyc;
        expect_evt(0, PRESS, p + 3);
        expect_evt(3, PRESS, p + 4);
        expect_evt(0, SHORT, p + 6);
        expect_evt(3, SHORT, p + 7);
        btn = 4'b1001;
        tick(3);
        btn = '0;
        drain("simul1_drain");

        // Tap button 0 alone to move the pointer to 0
        p = cyc;
        expect_evt(0, PRESS, p + 3);
        expect_evt(0, SHORT, p + 6);
        btn[0] = 1'b1;
        tick(3);
        btn[0] = 1'b0;
        drain("tap0_drain");

        // Same simultaneous press now resolves button 3 first
        p = cyc;
        expect_evt(3, PRESS, p + 3);
        expect_evt(0, PRESS, p + 4);
        expect_evt(3, SHORT, p + 6);
        expect_evt(0, SHORT, p + 7);
        btn = 4'b1001;
        tick(3);
        btn = '0;
        drain("simul2_drain");

        // Backpressure: two taps while stalled overwrite the slot
        ready = 1'b0;
        expect_evt(1, PRESS, -1);
        expect_evt(1, SHORT, -1);
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        tick(3);
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", valid, 1);
            chk("stall_btn", bidx, 1);
            chk("stall_code", code, PRESS);
        end
        tick(1);
        chk("stall_ovf", ovf, 4'b0010);
        ready = 1'b1;
        drain("bp_drain");
        chk("ovf_sticky", ovf, 4'b0010);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Button held across reset release produces nothing until re-pressed
        btn[0] = 1'b1;
        rst_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk("held_no_evt", valid, 0);
        btn[0] = 1'b0;
        tick(4);
        p = cyc;
        expect_evt(0, PRESS, p + 3);
        expect_evt(0, SHORT, p + 6);
        btn[0] = 1'b1;
        tick(3);
        btn[0] = 1'b0;
        drain("repress_drain");

        // Mid-operation reset discards pending and in-flight events
        ready = 1'b0;
        btn   = 4'b1100;
        tick(3);
        btn = '0;
        tick(3);
        btn[3] = 1'b1;
        tick(3);
        btn = '0;
        tick(4);
        chk("pre_rst_valid", valid, 1);
        chk("pre_rst_btn", bidx, 2);
        chk("pre_rst_ovf", ovf, 4'b1000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", valid, 0);
        chk("async_ovf", ovf, 0);
        tick(1);
        ready = 1'b1;
        rst_n = 1'b1;
        tick(12);
        chk("post_rst_valid", valid, 0);
        chk("final_queue", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
